// File: rtl/serial_pattern_detector.sv
// rtl/serial_pattern_detector.sv - runtime-loadable serial pattern detector
// Matches the newest len_q bits of a serial stream against a latched pattern.
module serial_pattern_detector #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;

  logic [PAT_W-1:0] nh;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] nf;
  logic [LEN_W-1:0] fill_d;
  logic [LEN_W-1:0] len_ld;
  logic             accept;
  logic             hit;

  always_comb begin
    nh     = {hist[PAT_W-2:0], in};
    nf     = (fill >= LEN_MAX) ? LEN_MAX : fill + 1'b1;
    accept = in_valid && !cfg_load;
    len_ld = (pat_len == '0 || pat_len > LEN_MAX) ? LEN_MAX : pat_len;
  end

  // Only the low len_q bits take part in the comparison.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  always_comb begin
    hit    = accept && (nf >= len_q) && (((nh ^ pat_q) & mask) == '0);
    fill_d = (hit && !ovl_q) ? '0 : nf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
      len_q <= LEN_MAX;
      ovl_q <= 1'b1;
    end else if (cfg_load) begin
      pat_q <= pattern;
      len_q <= len_ld;
      ovl_q <= overlap;
    end
  end

  // A fresh configuration restarts the window; the history itself is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
      armed <= 1'b0;
    end else if (cfg_load) begin
      fill  <= '0;
      match <= 1'b0;
      armed <= 1'b0;
    end else if (in_valid) begin
      hist  <= nh;
      fill  <= fill_d;
      match <= hit;
      armed <= (fill_d >= len_q);
    end else begin
      match <= 1'b0;
    end
  end

  // Clear takes effect first, so a simultaneous hit leaves a count of one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= hit ? CNT_W'(1) : '0;
    end else if (hit && match_cnt != CNT_MAX) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_pattern_detector.sv
// tb/tb_serial_pattern_detector.sv - bench for serial_pattern_detector
// Directed vector table, hand sequences and a queue-based random reference.
module tb_serial_pattern_detector;

  typedef struct {
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       vld;
    logic       b;
    logic       clr;
    logic       e_match;
    logic       e_armed;
    int         e_cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din, in_valid, cfg_load, overlap, cnt_clr;
  logic [7:0] pattern;
  logic [3:0] pat_len;
  logic       match, armed, match2, armed2;
  logic [7:0] match_cnt;
  logic [1:0] cnt2;

  int tests = 0;
  int fails = 0;

  bit         mq[$];
  logic [7:0] mpat;
  int         mlen;
  bit         movl;
  int         mcount;
  bit         m_match;

  vec_t tv[$];

  always #5 clk = ~clk;

  serial_pattern_detector #(.PAT_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in(din), .in_valid(in_valid), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
    .match(match), .match_cnt(match_cnt), .armed(armed)
  );

  serial_pattern_detector #(.PAT_W(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in(din), .in_valid(in_valid), .cfg_load(cfg_load),
    .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
    .match(match2), .match_cnt(cnt2), .armed(armed2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    mpat    = 8'h00;
    mlen    = 8;
    movl    = 1'b1;
    mcount  = 0;
    m_match = 1'b0;
  endtask

  // Window of bits received since the last load or non-overlapping hit.
  task automatic model_step(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                            input logic ovl, input logic vld, input logic b, input logic clr);
    bit h;
    h = 1'b0;
    if (ld) begin
      mpat = pat;
      mlen = (len == 0 || len > 8) ? 8 : int'(len);
      movl = ovl;
      mq.delete();
    end else if (vld) begin
      mq.push_back(b);
      if (mq.size() > 8) void'(mq.pop_front());
      if (mq.size() >= mlen) begin
        h = 1'b1;
        for (int k = 0; k < mlen; k++)
          if (mq[mq.size() - 1 - k] != mpat[k]) h = 1'b0;
      end
      if (h && !movl) mq.delete();
    end
    if (clr) mcount = h ? 1 : 0;
    else if (h) mcount++;
    m_match = h;
  endtask

  task automatic step(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                      input logic ovl, input logic vld, input logic b, input logic clr);
    cfg_load = ld; pattern = pat; pat_len = len; overlap = ovl;
    in_valid = vld; din = b; cnt_clr = clr;
    model_step(ld, pat, len, ovl, vld, b, clr);
    @(posedge clk);
    #1;
    cfg_load = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic add(input logic ld, input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                     input logic vld, input logic b, input logic clr,
                     input logic em, input logic ea, input int ec);
    vec_t v;
    v.ld = ld; v.pat = pat; v.len = len; v.ovl = ovl; v.vld = vld; v.b = b; v.clr = clr;
    v.e_match = em; v.e_armed = ea; v.e_cnt = ec;
    tv.push_back(v);
  endtask

  task automatic bit_add(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                         input logic b, input logic em, input logic ea, input int ec);
    add(1'b0, pat, len, ovl, 1'b1, b, 1'b0, em, ea, ec);
  endtask

  initial begin
    logic [6:0] ostream;
    logic       ld, vld, b, clr, ovl;
    logic [7:0] pat;
    logic [3:0] len;

    rst_n = 1'b0; din = 0; in_valid = 0; cfg_load = 0; overlap = 0; cnt_clr = 0;
    pattern = 8'h00; pat_len = 4'd0;
    model_reset();
    #12;
    chk("reset_match", match, 0);
    chk("reset_cnt", match_cnt, 0);
    chk("reset_armed", armed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Overlap: 1,0,1,1,0,1,1 against 4'b1011
    add(1, 8'h0B, 4, 1, 0, 0, 0, 0, 0, 0);
    bit_add(8'h0B, 4, 1, 1, 0, 0, 0); bit_add(8'h0B, 4, 1, 0, 0, 0, 0);
    bit_add(8'h0B, 4, 1, 1, 0, 0, 0); bit_add(8'h0B, 4, 1, 1, 1, 1, 1);
    bit_add(8'h0B, 4, 1, 0, 0, 1, 1); bit_add(8'h0B, 4, 1, 1, 0, 1, 1);
    bit_add(8'h0B, 4, 1, 1, 1, 1, 2);
    add(0, 8'h0B, 4, 1, 0, 0, 1, 0, 1, 0);
    // Non-overlap
    add(1, 8'h0B, 4, 0, 0, 0, 0, 0, 0, 0);
    bit_add(8'h0B, 4, 0, 1, 0, 0, 0); bit_add(8'h0B, 4, 0, 0, 0, 0, 0);
    bit_add(8'h0B, 4, 0, 1, 0, 0, 0); bit_add(8'h0B, 4, 0, 1, 1, 0, 1);
    bit_add(8'h0B, 4, 0, 0, 0, 0, 1); bit_add(8'h0B, 4, 0, 1, 0, 0, 1);
    bit_add(8'h0B, 4, 0, 1, 0, 0, 1);
    add(0, 8'h0B, 4, 0, 0, 0, 1, 0, 0, 0);
    // cfg_load wins over a bit on the same edge
    add(1, 8'h0B, 4, 1, 0, 0, 0, 0, 0, 0);
    bit_add(8'h0B, 4, 1, 1, 0, 0, 0); bit_add(8'h0B, 4, 1, 0, 0, 0, 0);
    bit_add(8'h0B, 4, 1, 1, 0, 0, 0);
    add(1, 8'h0B, 4, 1, 1, 1, 0, 0, 0, 0);
    bit_add(8'h0B, 4, 1, 1, 0, 0, 0); bit_add(8'h0B, 4, 1, 0, 0, 0, 0);
    bit_add(8'h0B, 4, 1, 1, 0, 0, 0); bit_add(8'h0B, 4, 1, 1, 1, 1, 1);
    // Length clamp: pat_len=0 means 8
    add(1, 8'hA5, 0, 1, 0, 0, 1, 0, 0, 0);
    bit_add(8'hA5, 0, 1, 1, 0, 0, 0); bit_add(8'hA5, 0, 1, 0, 0, 0, 0);
    bit_add(8'hA5, 0, 1, 1, 0, 0, 0); bit_add(8'hA5, 0, 1, 0, 0, 0, 0);
    bit_add(8'hA5, 0, 1, 0, 0, 0, 0); bit_add(8'hA5, 0, 1, 1, 0, 0, 0);
    bit_add(8'hA5, 0, 1, 0, 0, 0, 0); bit_add(8'hA5, 0, 1, 1, 1, 1, 1);
    // Saturation (dut2 holds at 3) and clear-then-count
    add(1, 8'h01, 1, 1, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) bit_add(8'h01, 1, 1, 1, 1, 1, k);
    bit_add(8'h01, 1, 1, 0, 0, 1, 6);
    add(0, 8'h01, 1, 1, 1, 1, 1, 1, 1, 1);
    add(0, 8'h01, 1, 1, 0, 0, 1, 0, 1, 0);
    // pat_len=1 non-overlap still hits every matching bit
    add(1, 8'h01, 1, 0, 0, 0, 0, 0, 0, 0);
    bit_add(8'h01, 1, 0, 1, 1, 0, 1); bit_add(8'h01, 1, 0, 1, 1, 0, 2);

    foreach (tv[i]) begin
      step(tv[i].ld, tv[i].pat, tv[i].len, tv[i].ovl, tv[i].vld, tv[i].b, tv[i].clr);
      chk($sformatf("vec%0d_match", i), match, tv[i].e_match);
      chk($sformatf("vec%0d_armed", i), armed, tv[i].e_armed);
      chk($sformatf("vec%0d_cnt", i), match_cnt, tv[i].e_cnt);
      chk($sformatf("vec%0d_cnt2", i), cnt2, sat(tv[i].e_cnt, 3));
    end

    // Gaps of three idle cycles between bits; pulses stay one cycle wide
    ostream = 7'b1101101;
    step(1, 8'h0B, 4, 1, 0, 0, 1);
    for (int k = 0; k < 7; k++) begin
      step(0, 8'h0B, 4, 1, 1, ostream[k], 0);
      chk($sformatf("gap_bit%0d_match", k + 1), match, (k == 3 || k == 6) ? 1 : 0);
      for (int g = 0; g < 3; g++) begin
        step(0, 8'h0B, 4, 1, 0, 0, 0);
        chk($sformatf("gap_idle%0d_%0d", k + 1, g), match, 0);
      end
    end
    chk("gap_cnt", match_cnt, 2);

    // Asynchronous reset while match is high
    step(1, 8'h0B, 4, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 8'h0B, 4, 1, 1, ostream[k], 0);
    chk("pre_rst_match", match, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_match", match, 0);
    chk("async_rst_cnt", match_cnt, 0);
    chk("async_rst_armed", armed, 0);
    chk("async_rst_hist", dut.hist, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    // Reset configuration: eight zeros match on the eighth
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0, 1, 0, 0);
      chk($sformatf("rst_cfg_bit%0d", k), match, (k == 8) ? 1 : 0);
    end

    // Random stream against the reference
    for (int n = 0; n < 3000; n++) begin
      ld  = ($urandom_range(0, 59) == 0);
      pat = 8'($urandom);
      len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      ovl = 1'($urandom);
      vld = ($urandom_range(0, 9) < 7);
      b   = 1'($urandom);
      clr = ($urandom_range(0, 39) == 0);
      step(ld, pat, len, ovl, vld, b, clr);
      chk("rnd_match", match, m_match);
      chk("rnd_armed", armed, (mq.size() >= mlen) ? 1 : 0);
      chk("rnd_cnt", match_cnt, sat(mcount, 255));
      chk("rnd_cnt2", cnt2, sat(mcount, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
